// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with a one-deep deferred redirect.
//
// A redirect that arrives while the front end is stalled is parked in a
// pending register (state PEND) and applied on the first unstalled edge,
// unless a fresh redirect arrives on that edge, in which case the live target
// is used instead.
//
// Parameters:
//   WIDTH     - address width of every port and internal register
//   RESET_PC  - pc value forced while reset is asserted
//   EXC_VEC   - exception entry address (only used with PC_GEN_EXC_VEC_EN)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   stall        in   hold pc when 1
//   redir_valid  in   redirect request this cycle
//   redir_target in   redirect destination (not masked; see misalign)
//   exc_req      in   exception request (only with PC_GEN_EXC_VEC_EN)
//   pc           out  current fetch address (registered)
//   pc4          out  pc + 4, wraps modulo 2^WIDTH (combinational)
//   pc8          out  pc + 8, delay-slot link address (combinational)
//   pend         out  1 while a deferred redirect is held
//   misalign     out  1 when pc[1:0] != 0 (combinational)
//
// Configuration macro: PC_GEN_EXC_VEC_EN adds the exc_req port, which has
// priority over stall and redirect and returns the machine to RUN.

module pc_gen #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
`ifdef PC_GEN_EXC_VEC_EN
  input  logic             exc_req,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] pc8,
  output logic             pend,
  output logic             misalign
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] w_tgt_nxt;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_pc8;

  // Sequential increments; the adders simply drop the carry out.
  assign w_pc4 = r_pc + WIDTH'(4);
  assign w_pc8 = r_pc + WIDTH'(8);

`ifndef PC_GEN_EXC_VEC_EN
  // The exception vector has no consumer in this build.
  logic w_unused_exc_vec;
  assign w_unused_exc_vec = ^EXC_VEC;
`endif

  // State, pc and pending-target registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Next-state / next-pc selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;

    case (r_state)
      ST_RUN: begin
        if (!stall) begin
          w_pc_nxt = redir_valid ? redir_target : w_pc4;
        end else if (redir_valid) begin
          w_tgt_nxt   = redir_target;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (stall) begin
          // Latest stalled redirect replaces the parked one.
          if (redir_valid) begin
            w_tgt_nxt = redir_target;
          end
        end else begin
          // A live redirect on the release edge beats the parked target.
          w_pc_nxt    = redir_valid ? redir_target : r_tgt;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

`ifdef PC_GEN_EXC_VEC_EN
    // Exception entry overrides everything except reset.
    if (exc_req) begin
      w_pc_nxt    = EXC_VEC;
      w_tgt_nxt   = '0;
      w_state_nxt = ST_RUN;
    end
`endif
  end

  assign pc       = r_pc;
  assign pc4      = w_pc4;
  assign pc8      = w_pc8;
  assign pend     = (r_state == ST_PEND);
  assign misalign = (r_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
`ifdef PC_GEN_EXC_VEC_EN
  logic        exc_req = 1'b0;
`endif
  logic [31:0] pc, pc4, pc8;
  logic        pend, misalign;

  pc_gen #(
    .WIDTH   (32),
    .RESET_PC(RST_PC),
    .EXC_VEC (EXC_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
`ifdef PC_GEN_EXC_VEC_EN
    .exc_req     (exc_req),
`endif
    .pc          (pc),
    .pc4         (pc4),
    .pc8         (pc8),
    .pend        (pend),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a fetch address plus an optional parked redirect.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_has;

  function automatic void m_reset();
    m_pc  = RST_PC;
    m_tgt = '0;
    m_has = 1'b0;
  endfunction

  function automatic void m_edge(bit s, bit rv, logic [31:0] t, bit exc);
    if (exc) begin
      m_pc  = EXC_PC;
      m_has = 1'b0;
    end else if (!s) begin
      if (rv)         m_pc = t;
      else if (m_has) m_pc = m_tgt;
      else            m_pc = m_pc + 32'd4;
      m_has = 1'b0;
    end else if (rv) begin
      m_has = 1'b1;
      m_tgt = t;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},       pc,                m_pc);
    chk({tag, ".pc4"},      pc4,               m_pc + 32'd4);
    chk({tag, ".pc8"},      pc8,               m_pc + 32'd8);
    chk({tag, ".pend"},     32'(pend),         32'(m_has));
    chk({tag, ".misalign"}, 32'(misalign),     32'(m_pc[1:0] != 2'b00));
  endtask

  // Apply inputs, take one rising edge, advance the model, check #1 later.
  task automatic step(input string tag, input bit s, input bit rv,
                      input logic [31:0] t, input bit exc);
    stall        = s;
    redir_valid  = rv;
    redir_target = t;
`ifdef PC_GEN_EXC_VEC_EN
    exc_req      = exc;
`endif
    @(posedge clk);
    m_edge(s, rv, t, exc);
    #1;
    chk_all(tag);
  endtask

  // Assert reset between edges and check it acts without a clock edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    m_reset();
    chk_all(tag);
    chk({tag, ".pc_const"}, pc, RST_PC);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    bit          s, rv, ex;

    m_reset();
    #1 reset = 1'b0;
    #2;
    chk("rst.pc",   pc,  32'h0000_3000);
    chk("rst.pc4",  pc4, 32'h0000_3004);
    chk("rst.pc8",  pc8, 32'h0000_3008);
    chk("rst.pend", 32'(pend), 32'd0);
    chk_all("rst");
    @(negedge clk);
    reset = 1'b1;

    step("run1", 0, 0, '0, 0);
    step("run2", 0, 0, '0, 0);
    step("run3", 0, 0, '0, 0);
    chk("run3.const", pc, 32'h0000_300C);

    // Plain redirect with one-cycle latency.
    step("to3008", 0, 1, 32'h0000_3008, 0);
    step("redir",  0, 1, 32'h0000_3100, 0);
    chk("redir.const", pc, 32'h0000_3100);
    step("redir+4", 0, 0, '0, 0);
    chk("redir+4.const", pc, 32'h0000_3104);

    // Deferred redirect.
    step("to3010", 0, 1, 32'h0000_3010, 0);
    step("defer1", 1, 1, 32'h0000_3200, 0);
    chk("defer1.pc", pc, 32'h0000_3010);
    chk("defer1.pend", 32'(pend), 32'd1);
    step("defer2", 1, 0, '0, 0);
    chk("defer2.pc", pc, 32'h0000_3010);
    step("defer_rel", 0, 0, '0, 0);
    chk("defer_rel.pc", pc, 32'h0000_3200);
    chk("defer_rel.pend", 32'(pend), 32'd0);

    // Latest stalled redirect wins.
    step("ow0", 1, 1, 32'h0000_3200, 0);
    step("ow1", 1, 1, 32'h0000_3300, 0);
    step("ow_rel", 0, 0, '0, 0);
    chk("ow_rel.pc", pc, 32'h0000_3300);

    // Live redirect beats the parked one.
    step("live0", 1, 1, 32'h0000_3200, 0);
    step("live1", 0, 1, 32'h0000_3400, 0);
    chk("live1.pc", pc, 32'h0000_3400);
    chk("live1.pend", 32'(pend), 32'd0);

    // Wrap-around and misalignment.
    step("wrap0", 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap0.pc8", pc8, 32'h0000_0004);
    chk("wrap0.pc4", pc4, 32'h0000_0000);
    step("wrap1", 0, 0, '0, 0);
    chk("wrap1.pc", pc, 32'h0000_0000);
    step("mis0", 0, 1, 32'h0000_3002, 0);
    chk("mis0.misalign", 32'(misalign), 32'd1);
    chk("mis0.pc", pc, 32'h0000_3002);
    step("mis1", 0, 0, '0, 0);

    // Reset in PEND discards the parked redirect.
    step("rpend", 1, 1, 32'h0000_3500, 0);
    async_reset("arst");
    chk("arst.pend", 32'(pend), 32'd0);
    step("arst_run", 0, 0, '0, 0);
    chk("arst_run.pc", pc, 32'h0000_3004);

`ifdef PC_GEN_EXC_VEC_EN
    step("exc0", 1, 1, 32'h0000_3600, 0);
    step("exc1", 1, 1, 32'h0000_3700, 1);
    chk("exc1.pc", pc, 32'h0000_4180);
    chk("exc1.pend", 32'(pend), 32'd0);
    step("exc2", 0, 0, '0, 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 9) < 3);
      t  = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
      ex = 1'b0;
`ifdef PC_GEN_EXC_VEC_EN
      ex = ($urandom_range(0, 19) == 0);
`endif
      step("rnd", s, rv, t, ex);
      if ($urandom_range(0, 49) == 0) async_reset("rnd_arst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the bit width of every address port and internal register.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, giving the program counter value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h0000_4180, giving the exception entry address (used only under REQ-030).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port stall  input  1  holds the PC when 1.
REQ-007 SHALL have port redir_valid  input  1  redirect request (branch/jump resolved) this cycle.
REQ-008 SHALL have port redir_target  input  WIDTH  redirect destination address.
REQ-009 SHALL have port pc  output  WIDTH  current fetch address (registered).
REQ-010 SHALL have port pc4  output  WIDTH  pc + 4 (combinational).
REQ-011 SHALL have port pc8  output  WIDTH  pc + 8, link address for delay-slot calls (combinational).
REQ-012 SHALL have port pend  output  1  1 while a deferred redirect is held (state PEND).
REQ-013 SHALL have port misalign  output  1  1 when pc[1:0] != 0 (combinational).

Function
REQ-014 SHALL implement a two-state machine: RUN (no pending redirect) and PEND (redirect target held in an internal WIDTH-bit register).
REQ-015 SHALL, in RUN with stall=0 and redir_valid=0, load pc <= pc + 4 on each rising edge.
REQ-016 SHALL, in RUN with stall=0 and redir_valid=1, load pc <= redir_target on the next edge (1-cycle latency), staying in RUN.
REQ-017 SHALL, in RUN with stall=1 and redir_valid=0, hold pc unchanged.
REQ-018 SHALL, in RUN with stall=1 and redir_valid=1, hold pc, capture redir_target into the pending register and go to PEND.
REQ-019 SHALL, in PEND with stall=1, hold pc; if redir_valid=1 the pending register is overwritten with redir_target (latest wins).
REQ-020 SHALL, in PEND with stall=0 and redir_valid=0, load pc <= pending register and return to RUN.
REQ-021 SHALL, in PEND with stall=0 and redir_valid=1, load pc <= redir_target (live input beats pending) and return to RUN.
REQ-022 SHALL compute pc+4, pc4 and pc8 modulo 2^WIDTH; 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
REQ-023 SHALL pass redir_target unmodified (no low-bit masking); misaligned targets are reported only via misalign.
REQ-024 SHALL drive pend = 1 exactly when state is PEND.

Reset
REQ-025 SHALL, while reset=0, immediately (asynchronously) force pc = RESET_PC, state = RUN, pend = 0, pending register = 0.
REQ-026 SHALL therefore present pc4 = RESET_PC+4, pc8 = RESET_PC+8, misalign = RESET_PC[1:0]!=0 during reset.
REQ-027 SHALL, on reset assertion mid-operation (including in PEND), discard any pending redirect.
REQ-028 SHALL resume REQ-015..021 behaviour from the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL support the macro PC_GEN_EXC_VEC_EN; when undefined, no exc_req port exists and behaviour is exactly REQ-014..028.
REQ-030 SHALL, when PC_GEN_EXC_VEC_EN is defined, add port exc_req (input, 1) which, when 1 at a rising edge, loads pc <= EXC_VEC, clears the pending register, forces state RUN, and overrides stall and redir_valid (highest priority below reset).

Verification
REQ-031 SHALL verify reset: reset=0 -> pc=0x3000, pc4=0x3004, pc8=0x3008, pend=0; release, 3 edges with stall=0 -> pc=0x300C.
REQ-032 SHALL verify redirect: pc=0x3008, redir_valid=1, target=0x3100, stall=0 -> next edge pc=0x3100, following edge 0x3104.
REQ-033 SHALL verify deferred redirect: pc=0x3010, stall=1 with redir_valid=1 target=0x3200 -> pend=1, pc holds 0x3010 for 2 stalled cycles; stall=0 -> pc=0x3200, pend=0.
REQ-034 SHALL verify overwrite and priority: in PEND (target 0x3200) stalled redirect to 0x3300 -> release gives 0x3300; second run with stall=0 and live target 0x3400 in PEND -> pc=0x3400.
REQ-035 SHALL verify wrap and misalign: redirect to 0xFFFF_FFFC -> pc8=0x0000_0004, next pc=0x0000_0000; redirect to 0x3002 -> misalign=1.
REQ-036 SHALL verify (macro defined) exc_req=1 while stall=1 in PEND -> next edge pc=0x4180, pend=0; plus reset=0 mid-PEND -> pc=0x3000 without waiting for clk.
